// File: rtl/sm_muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Holds the operation codes, the FSM encoding and the MULTU/DIVU/MFHI/MFLO/MTHI/MTLO funct codes.
package sm_muldiv_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_DIVU  = 2'b01,
    MDU_MTHI  = 2'b10,
    MDU_MTLO  = 2'b11
  } mduOp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mduState_e;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1b;

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the shared shift/add-subtract datapath, purely combinational.
// Multiply: {workHi,workLo} is the accumulator. Divide: workHi is the remainder, workLo the quotient.
module sm_muldiv_step
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mduOp_e           mode,
  input  logic [WIDTH-1:0] workHi,
  input  logic [WIDTH-1:0] workLo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0] mulSum_s;
  logic [WIDTH:0] divShift_s;
  logic [WIDTH:0] divDiff_s;

  // Next working registers for the selected operation
  always_comb begin
    mulSum_s   = '0;
    divShift_s = '0;
    divDiff_s  = '0;
    nextHi     = '0;
    nextLo     = '0;
    case (mode)
      MDU_DIVU: begin
        // Keep the bit shifted out of the remainder so the compare is WIDTH+1 wide
        divShift_s = {workHi, workLo[WIDTH-1]};
        divDiff_s  = divShift_s - {1'b0, operand};
        if (divShift_s >= {1'b0, operand}) begin
          nextHi = divDiff_s[WIDTH-1:0];
          nextLo = {workLo[WIDTH-2:0], 1'b1};
        end else begin
          nextHi = divShift_s[WIDTH-1:0];
          nextLo = {workLo[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        if (workLo[0]) begin
          mulSum_s = {1'b0, workHi} + {1'b0, operand};
        end else begin
          mulSum_s = {1'b0, workHi};
        end
        nextHi = mulSum_s[WIDTH:1];
        nextLo = {mulSum_s[0], workLo[WIDTH-1:1]};
      end
    endcase
  end

endmodule

// File: rtl/sm_muldiv.sv
// Multi-cycle unsigned MULTU/DIVU unit with HI/LO registers, one bit per clock.
// hi/lo only change on commit, divide-by-zero, or MTHI/MTLO; working registers carry the iteration.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mduState_e        state_r;
  mduState_e        stateNext_s;
  mduOp_e           oper_s;
  mduOp_e           mode_r;
  logic             accept_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] workHi_r;
  logic [WIDTH-1:0] workLo_r;
  logic [WIDTH-1:0] operand_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] stepHi_s;
  logic [WIDTH-1:0] stepLo_s;

  assign oper_s   = mduOp_e'(oper);
  assign accept_s = start && !abort && (state_r != S_RUN);
  assign busy     = (state_r == S_RUN);
  assign done     = (state_r == S_DONE);
  assign hi       = hi_r;
  assign lo       = lo_r;

  sm_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (mode_r),
    .workHi  (workHi_r),
    .workLo  (workLo_r),
    .operand (operand_r),
    .nextHi  (stepHi_s),
    .nextLo  (stepLo_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode; abort in RUN wins over the final commit
  always_comb begin
    stateNext_s = S_IDLE;
    case (state_r)
      S_RUN: begin
        if (abort) begin
          stateNext_s = S_IDLE;
        end else if (count_r == '0) begin
          stateNext_s = S_DONE;
        end else begin
          stateNext_s = S_RUN;
        end
      end
      default: begin
        if (accept_s) begin
          case (oper_s)
            MDU_MULTU: stateNext_s = S_RUN;
            MDU_DIVU:  stateNext_s = (srcB == '0) ? S_DONE : S_RUN;
            default:   stateNext_s = S_IDLE;
          endcase
        end else begin
          stateNext_s = S_IDLE;
        end
      end
    endcase
  end

  // Operand latch, iteration, counter and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= '0;
      workHi_r  <= '0;
      workLo_r  <= '0;
      operand_r <= '0;
      mode_r    <= MDU_MULTU;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state_r)
        S_RUN: begin
          workHi_r <= stepHi_s;
          workLo_r <= stepLo_s;
          count_r  <= count_r - CW'(1);
          if (!abort && (count_r == '0)) begin
            hi_r <= stepHi_s;
            lo_r <= stepLo_s;
          end
        end
        default: begin
          if (accept_s) begin
            case (oper_s)
              MDU_MULTU: begin
                workHi_r  <= '0;
                workLo_r  <= srcB;
                operand_r <= srcA;
                mode_r    <= MDU_MULTU;
                count_r   <= CW'(WIDTH - 1);
              end
              MDU_DIVU: begin
                if (srcB == '0) begin
                  hi_r <= srcA;
                  lo_r <= '1;
                end else begin
                  workHi_r  <= '0;
                  workLo_r  <= srcA;
                  operand_r <= srcB;
                  mode_r    <= MDU_DIVU;
                  count_r   <= CW'(WIDTH - 1);
                end
              end
              MDU_MTHI: hi_r <= srcA;
              default:  lo_r <= srcA;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// Randomized and directed bench for sm_muldiv against a plain-arithmetic HI/LO model.
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   oper;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checkCount = 0;
  int passCount  = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;

  sm_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .oper  (oper),
    .srcA  (srcA),
    .srcB  (srcB),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue MULTU/DIVU in the current cycle (b2b) or the next one; check latency, busy window, hold and result
  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit b2b, input string tag);
    logic [63:0]  prod;
    logic [W-1:0] eHi, eLo, oldHi, oldLo;
    int expDone, doneCyc;
    bit busyOk, holdOk, expBusy;
    if (!b2b) @(negedge clk);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    oldHi = mHi; oldLo = mLo;
    if (op == MDU_MULTU) begin
      prod = 64'(a) * 64'(b);
      eHi = prod[63:32]; eLo = prod[31:0]; expDone = W + 1;
    end else if (b == '0) begin
      eHi = a; eLo = '1; expDone = 1;
    end else begin
      eHi = a % b; eLo = a / b; expDone = W + 1;
    end
    doneCyc = 0; busyOk = 1'b1; holdOk = 1'b1;
    for (int cyc = 1; cyc <= 60 && doneCyc == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0; srcA = $urandom; srcB = $urandom;
      expBusy = (expDone == W + 1) && (cyc <= W);
      if (busy !== expBusy) busyOk = 1'b0;
      if (done === 1'b1) doneCyc = cyc;
      else if (hi !== oldHi || lo !== oldLo) holdOk = 1'b0;
    end
    checkEq({tag, " doneCycle"}, 64'(doneCyc), 64'(expDone));
    checkEq({tag, " busyWindow"}, 64'(busyOk), 64'd1);
    checkEq({tag, " hiloHold"}, 64'(holdOk), 64'd1);
    checkEq({tag, " hi"}, 64'(hi), 64'(eHi));
    checkEq({tag, " lo"}, 64'(lo), 64'(eLo));
    mHi = eHi; mLo = eLo;
  endtask

  task automatic mtOp(input logic [1:0] op, input logic [W-1:0] a, input string tag);
    @(negedge clk);
    start = 1'b1; oper = op; srcA = a;
    @(negedge clk);
    start = 1'b0;
    if (op == MDU_MTHI) mHi = a; else mLo = a;
    checkEq({tag, " hi"}, 64'(hi), 64'(mHi));
    checkEq({tag, " lo"}, 64'(lo), 64'(mLo));
    checkEq({tag, " noDoneBusy"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    bit abortBusyOk, sawDone;
    int r;
    logic [1:0] op;
    logic [W-1:0] a, b;
    bit lastDone;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; oper = 2'b00; srcA = '0; srcB = '0;
    #12;
    checkEq("reset outputs", {busy, done, 30'd0, hi}, 64'd0);
    checkEq("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(MDU_MULTU, 32'd3, 32'd5, 1'b0, "mul3x5");
    runOp(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulMax");
    runOp(MDU_DIVU, 32'd100, 32'd7, 1'b0, "div100by7");
    runOp(MDU_DIVU, 32'h80000000, 32'd1, 1'b0, "divMsbBy1");
    runOp(MDU_DIVU, 32'd42, 32'd0, 1'b0, "divBy0");
    runOp(MDU_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "divBigDivisor");
    mtOp(MDU_MTLO, 32'h12345678, "mtlo");
    mtOp(MDU_MTHI, 32'hA5A5A5A5, "mthi");

    // MULTU 2*2 with stray start pulses during RUN and abort in cycle 10
    @(negedge clk);
    start = 1'b1; oper = MDU_MULTU; srcA = 32'd2; srcB = 32'd2;
    abortBusyOk = 1'b1; sawDone = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc <= 10 && busy !== 1'b1) abortBusyOk = 1'b0;
      if (cyc == 11) checkEq("abort idleCycle11", 64'({busy, done}), 64'd0);
      if (done === 1'b1) sawDone = 1'b1;
      start = (cyc == 3 || cyc == 5 || cyc == 7);
      oper  = MDU_MTHI; srcA = $urandom;
      abort = (cyc == 10);
    end
    start = 1'b0; abort = 1'b0;
    checkEq("abort busyBefore", 64'(abortBusyOk), 64'd1);
    checkEq("abort noDone", 64'(sawDone), 64'd0);
    checkEq("abort hi", 64'(hi), 64'h00000000A5A5A5A5);
    checkEq("abort lo", 64'(lo), 64'(mLo));

    runOp(MDU_MULTU, 32'd3, 32'd5, 1'b0, "preB2b");
    runOp(MDU_DIVU, 32'd100, 32'd7, 1'b1, "b2bDiv");
    runOp(MDU_DIVU, 32'd42, 32'd0, 1'b1, "b2bDiv0");

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; oper = MDU_MULTU; srcA = 32'd7; srcB = 32'd9;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkEq("asyncReset busyDone", 64'({busy, done}), 64'd0);
    checkEq("asyncReset hi", 64'(hi), 64'd0);
    checkEq("asyncReset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mHi = '0; mLo = '0;
    runOp(MDU_MULTU, 32'd7, 32'd9, 1'b0, "afterReset");

    lastDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      r  = $urandom_range(0, 3);
      b  = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 255)) : 32'($urandom);
      if (op == MDU_MTHI || op == MDU_MTLO) begin
        mtOp(op, a, "rndMt");
        lastDone = 1'b0;
      end else begin
        runOp(op, a, b, lastDone && ($urandom_range(0, 1) == 1), "rnd");
        lastDone = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
